sipo_rx_ctrl: RTL and testbench
===============================

# sipo_rx_ctrl

Serial receive controller that frames an asynchronous, idle-high serial line into bytes. It oversamples the line, detects and validates the start bit, and strobes each data bit mid-bit. It drives the enable/valid/data-in sideband of the existing serial-in parallel-out shifter. It also assembles its own byte and hands it to the consumer over a valid/ready handshake, with frame, parity and overrun reporting.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 4..1024; counter width is $clog2(CLKS_PER_BIT).
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- rx_in  input  1  asynchronous serial line; idle high; LSB first.
- sipo_en  output  1  enable to shifter; high from start-bit confirmation until the frame ends.
- sipo_valid  output  1  one-cycle strobe per data bit (8 per frame).
- sipo_din  output  1  sampled data bit; meaningful when sipo_valid=1.
- byte_out  output  8  received byte; stable while byte_valid=1.
- byte_valid  output  1  byte available.
- byte_ready  input  1  consumer accepts byte when byte_valid&byte_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.
- overrun  output  1  one-cycle pulse: new byte loaded while the previous one was unaccepted.

## Operation
- rx_in passes through a 2-flop synchronizer (reset value 1). All statements below refer to the synchronized line, rxs.
- States: IDLE, START, DATA, PARITY (only if compiled in), STOP.
- IDLE: on rxs=0, go to START and clear the cycle counter.
- START: at counter = CLKS_PER_BIT/2-1 (integer division), sample rxs.
  - rxs=0: go to DATA, clear counter and bit_cnt, assert sipo_en.
  - rxs=1: glitch; return to IDLE with no outputs.
- DATA: sample when counter = CLKS_PER_BIT-1, then the counter wraps to 0.
  - Each sample pulses sipo_valid with sipo_din = rxs.
  - Each sample also shifts right into the assembly register with the new bit at [7], so the first bit ends in [0].
  - After the 8th sample (bit_cnt=7), go to PARITY or STOP.
- PARITY: sample once at the same point. Even parity: the XOR of 8 data bits and the parity bit must be 0. The result is held until STOP completes.
- STOP: sample once at the same point; in all cases deassert sipo_en and return to IDLE.
  - rxs=1 and parity good: load byte_out, set byte_valid.
  - rxs=0: pulse frame_err and discard the byte. frame_err takes priority; no parity_err in the same frame.
  - rxs=1 and parity bad: pulse parity_err and discard the byte.
- Handshake:
  - byte_valid clears on the cycle after byte_valid&byte_ready.
  - byte_out is not modified while byte_valid=1, except by an overrun load.
- Overrun: a load while byte_valid=1 and byte_ready=0 overwrites byte_out, keeps byte_valid=1 and pulses overrun. A load in the same cycle as acceptance is not an overrun; byte_valid stays 1 with the new byte.
- Reset (any cycle, including mid-frame): state IDLE; counters 0; byte_out=0; assembly register=0; all outputs 0; the partial frame is dropped.

## Timing
- Synchronizer latency: 2 cycles from rx_in to rxs.
- Start confirmation: CLKS_PER_BIT/2 cycles after the first rxs=0 cycle in IDLE.
- Data sample k (k=0..7): CLKS_PER_BIT*(k+1) cycles after start confirmation. sipo_valid is registered and high in the cycle after the sample edge.
- byte_valid, frame_err and parity_err are registered and rise the cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered the cycle after the stop sample, so a start edge one cycle later is accepted.
- A frame occupies 1 + 8 (+1) + 1 bit periods; the controller does not check for a line break.

## Configuration
- RX_PARITY_EN defined:
  - PARITY state present; frame is start, 8 data, even parity, stop.
  - parity_err active.
- RX_PARITY_EN undefined:
  - STOP follows DATA directly; frame is start, 8 data, stop.
  - parity_err tied 0.

## Test plan
- Reset mid-frame: after the 4th sipo_valid, pull rst low one cycle -> all outputs 0, state IDLE. The next full frame 0xA5 is received correctly.
- Single byte, CLKS_PER_BIT=16, frame 0x5A, parity off -> exactly 8 sipo_valid pulses with sipo_din 0,1,0,1,1,0,1,0. byte_out=0x5A and byte_valid=1 one cycle after the stop sample; byte_ready=1 clears it next cycle.
- Glitch: rx_in low for 3 cycles, then high -> no sipo_en, no sipo_valid, state back in IDLE.
- Framing error: send 0x3C with the stop bit low -> frame_err one-cycle pulse, byte_valid stays 0, byte_out unchanged.
- Overrun and simultaneous accept:
  - Send 0x11 then 0x22 with byte_ready=0 -> overrun pulse, byte_out=0x22, byte_valid=1.
  - Repeat with byte_ready=1 exactly on the load cycle -> no overrun.
- RX_PARITY_EN defined:
  - 0x07 with parity bit 1 -> byte_valid, byte_out=0x07.
  - 0x07 with parity bit 0 -> parity_err pulse, no byte_valid.

Source files
------------

// File: rtl/sipo_rx_ctrl_if.sv
// Signal bundle for sipo_rx_ctrl: serial line in, shifter sideband and byte handshake out.
// The master side is the receive controller; the slave side is the line driver / byte consumer.
interface sipo_rx_ctrl_if;
    logic       rx_in;
    logic       sipo_en;
    logic       sipo_valid;
    logic       sipo_din;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    modport master (
        input  rx_in, byte_ready,
        output sipo_en, sipo_valid, sipo_din, byte_out, byte_valid,
               frame_err, parity_err, overrun
    );

    modport slave (
        output rx_in, byte_ready,
        input  sipo_en, sipo_valid, sipo_din, byte_out, byte_valid,
               frame_err, parity_err, overrun
    );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// Oversampling serial receive controller: frames an idle-high line into bytes with valid/ready hand-off.
// Define RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module sipo_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    sipo_rx_ctrl_if.master bus
);
    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          r_state;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bitCnt;
    logic [7:0]      r_shift;
    logic            r_sipoEn;
    logic            r_sipoValid;
    logic            r_sipoDin;
    logic [7:0]      r_byteOut;
    logic            r_byteValid;
    logic            r_frameErr;
    logic            r_overrun;
    logic            w_rxs;
    logic            w_parBad;

`ifdef RX_PARITY_EN
    logic            r_parAcc;
    logic            r_parBad;
    logic            r_parErr;
    assign w_parBad       = r_parBad;
    assign bus.parity_err = r_parErr;
`else
    assign w_parBad       = 1'b0;
    assign bus.parity_err = 1'b0;
`endif

    assign w_rxs          = r_sync[1];
    assign bus.sipo_en    = r_sipoEn;
    assign bus.sipo_valid = r_sipoValid;
    assign bus.sipo_din   = r_sipoDin;
    assign bus.byte_out   = r_byteOut;
    assign bus.byte_valid = r_byteValid;
    assign bus.frame_err  = r_frameErr;
    assign bus.overrun    = r_overrun;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_sync      <= 2'b11;
            r_cnt       <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_sipoEn    <= 1'b0;
            r_sipoValid <= 1'b0;
            r_sipoDin   <= 1'b0;
            r_byteOut   <= '0;
            r_byteValid <= 1'b0;
            r_frameErr  <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef RX_PARITY_EN
            r_parAcc    <= 1'b0;
            r_parBad    <= 1'b0;
            r_parErr    <= 1'b0;
`endif
        end else begin
            r_sync      <= {r_sync[0], bus.rx_in};
            r_sipoValid <= 1'b0;
            r_frameErr  <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef RX_PARITY_EN
            r_parErr    <= 1'b0;
`endif
            // An accept is overridden below when a new byte lands in the same cycle.
            if (r_byteValid && bus.byte_ready) begin
                r_byteValid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == HALF_CNT) begin
                        if (!w_rxs) begin
                            r_state  <= DATA;
                            r_cnt    <= '0;
                            r_bitCnt <= '0;
                            r_sipoEn <= 1'b1;
`ifdef RX_PARITY_EN
                            r_parAcc <= 1'b0;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt       <= '0;
                        r_sipoValid <= 1'b1;
                        r_sipoDin   <= w_rxs;
                        r_shift     <= {w_rxs, r_shift[7:1]};
                        r_bitCnt    <= r_bitCnt + 3'd1;
`ifdef RX_PARITY_EN
                        r_parAcc    <= r_parAcc ^ w_rxs;
                        if (r_bitCnt == 3'd7) r_state <= PARITY;
`else
                        if (r_bitCnt == 3'd7) r_state <= STOP;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt    <= '0;
                        r_parBad <= r_parAcc ^ w_rxs;
                        r_state  <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt    <= '0;
                        r_sipoEn <= 1'b0;
                        r_state  <= IDLE;
                        if (!w_rxs) begin
                            r_frameErr <= 1'b1;
                        end else if (w_parBad) begin
`ifdef RX_PARITY_EN
                            r_parErr <= 1'b1;
`endif
                        end else begin
                            r_byteOut   <= r_shift;
                            r_byteValid <= 1'b1;
                            r_overrun   <= r_byteValid && !bus.byte_ready;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Scoreboard bench for sipo_rx_ctrl: frames are generated from byte values, expected
// bits/bytes/errors are queued by a frame-level model and popped by negedge monitors.
module tb_sipo_rx_ctrl;
    localparam int CPB = 16;
`ifdef RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Posedge index (counted from the edge the start bit is launched after) of the stop sample.
    localparam int LOAD_EDGE = CPB * (NBITS - 1) + CPB / 2 + 3;

    typedef struct {
        logic [7:0] data;
        logic       ovr;
    } byte_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sipo_rx_ctrl_if bus();

    sipo_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    byte_exp_t  byteQ[$];
    logic       bitQ[$];
    logic [1:0] errQ[$];

    int         checks       = 0;
    int         passes       = 0;
    int         sipoCnt      = 0;
    int         sipoEnCnt    = 0;
    logic       modelPending = 1'b0;
    logic [7:0] modelLast    = 8'h00;
    logic       prevValid    = 1'b0;
    logic       prevReady    = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every shifter strobe, every byte load and every error pulse consumes one expectation.
    always @(negedge clk) begin : monitor
        byte_exp_t  e;
        logic       b;
        logic [1:0] er;
        if (bus.sipo_en) sipoEnCnt++;
        if (bus.sipo_valid) begin
            sipoCnt++;
            if (bitQ.size() == 0) begin
                checkOutput("unexpected sipo_valid", 1, 0);
            end else begin
                b = bitQ.pop_front();
                checkOutput("sipo_din", bus.sipo_din, b);
                checkOutput("sipo_en with strobe", bus.sipo_en, 1);
            end
        end
        if (bus.byte_valid && (!prevValid || bus.overrun || (prevValid && prevReady))) begin
            if (byteQ.size() == 0) begin
                checkOutput("unexpected byte load", bus.byte_out, 32'hFFFF_FFFF);
            end else begin
                e = byteQ.pop_front();
                checkOutput("byte_out", bus.byte_out, e.data);
                checkOutput("overrun", bus.overrun, e.ovr);
            end
        end
        if (bus.frame_err || bus.parity_err) begin
            if (errQ.size() == 0) begin
                checkOutput("unexpected error pulse", {bus.frame_err, bus.parity_err}, 0);
            end else begin
                er = errQ.pop_front();
                checkOutput("frame_err/parity_err", {bus.frame_err, bus.parity_err}, er);
                checkOutput("byte_out kept on error", bus.byte_out, modelLast);
            end
        end
        prevValid = bus.byte_valid;
        prevReady = bus.byte_ready;
    end

    // mode 0: byte_ready low throughout; 1: high throughout; 2: high only on the load edge.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic parBit,
                                 input int mode);
        logic bits [NBITS];
        logic isLoad;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (NBITS == 11) bits[NBITS-2] = parBit;
        bits[NBITS-1] = stopBit;
        for (int i = 0; i < 8; i++) bitQ.push_back(d[i]);

        isLoad = 1'b0;
        if (!stopBit) errQ.push_back(2'b10);
`ifdef RX_PARITY_EN
        else if ((^d) ^ parBit) errQ.push_back(2'b01);
`endif
        else isLoad = 1'b1;
        if (isLoad) begin
            byteQ.push_back('{data: d, ovr: modelPending && (mode == 0)});
            modelLast    = d;
            modelPending = (mode != 1);
        end else begin
            modelPending = modelPending && (mode == 0);
        end

        bus.byte_ready = (mode == 1);
        fork
            begin
                @(posedge clk);
                #1 bus.rx_in = bits[0];
                for (int i = 1; i < NBITS; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1 bus.rx_in = bits[i];
                end
                repeat (CPB) @(posedge clk);
                #1 bus.rx_in = 1'b1;
                if (!stopBit) repeat (2 * CPB) @(posedge clk);
            end
            begin
                if (mode == 2) begin
                    @(posedge clk);
                    repeat (LOAD_EDGE - 1) @(posedge clk);
                    #1 bus.byte_ready = 1'b1;
                    @(posedge clk);
                    #1 bus.byte_ready = 1'b0;
                end
            end
        join
    endtask

    task automatic drainByte();
        @(posedge clk);
        #1 bus.byte_ready = 1'b1;
        @(posedge clk);
        #1 bus.byte_ready = 1'b0;
        modelPending = 1'b0;
    endtask

    initial begin : stimulus
        int         s0;
        logic [7:0] d;
        logic       stopBit;
        logic       parBit;
        bus.rx_in      = 1'b1;
        bus.byte_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset sipo_en", bus.sipo_en, 0);
        checkOutput("reset sipo_valid", bus.sipo_valid, 0);
        checkOutput("reset byte_valid", bus.byte_valid, 0);
        checkOutput("reset byte_out", bus.byte_out, 0);
        checkOutput("reset errors", {bus.frame_err, bus.parity_err, bus.overrun}, 0);

        // Single byte, then accept it and see byte_valid drop.
        s0 = sipoCnt;
        applyStimulus(8'h5A, 1'b1, 1'b0, 0);
        checkOutput("strobe count 0x5A", sipoCnt - s0, 8);
        checkOutput("byte_valid held", bus.byte_valid, 1);
        @(posedge clk);
        #1 bus.byte_ready = 1'b1;
        @(posedge clk);
        #1 bus.byte_ready = 1'b0;
        modelPending = 1'b0;
        @(negedge clk);
        checkOutput("byte_valid after accept", bus.byte_valid, 0);

        // Short low glitch must not start a frame.
        s0 = sipoEnCnt;
        @(posedge clk);
        #1 bus.rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.rx_in = 1'b1;
        repeat (40) @(posedge clk);
        checkOutput("glitch sipo_en cycles", sipoEnCnt - s0, 0);

        // Framing error.
        applyStimulus(8'h3C, 1'b0, ^8'h3C, 0);
        checkOutput("byte_valid after frame_err", bus.byte_valid, 0);

        // Overrun, then a load coinciding with acceptance.
        applyStimulus(8'h11, 1'b1, ^8'h11, 0);
        applyStimulus(8'h22, 1'b1, ^8'h22, 0);
        checkOutput("byte_valid after overrun", bus.byte_valid, 1);
        applyStimulus(8'h33, 1'b1, ^8'h33, 2);
        checkOutput("byte_valid after accept+load", bus.byte_valid, 1);
        drainByte();

        // Reset after the fourth strobe drops the partial frame.
        s0 = sipoCnt;
        d  = 8'hC3;
        for (int i = 0; i < 4; i++) bitQ.push_back(d[i]);
        @(posedge clk);
        #1 bus.rx_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (CPB) @(posedge clk);
            #1 bus.rx_in = d[i];
        end
        repeat (CPB) @(posedge clk);
        #1 bus.rx_in = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        modelPending = 1'b0;
        modelLast    = 8'h00;
        @(negedge clk);
        checkOutput("strobes before reset", sipoCnt - s0, 4);
        checkOutput("mid-frame reset outputs",
                    {bus.sipo_en, bus.sipo_valid, bus.byte_valid, bus.frame_err,
                     bus.parity_err, bus.overrun, bus.byte_out}, 0);
        applyStimulus(8'hA5, 1'b1, ^8'hA5, 1);

`ifdef RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b1, 1);
        applyStimulus(8'h07, 1'b1, 1'b0, 1);
`endif

        // Randomized back-to-back frames with occasional stop/parity faults.
        for (int n = 0; n < 24; n++) begin
            d       = 8'($urandom);
            stopBit = ($urandom_range(0, 6) != 0);
            parBit  = (^d) ^ ($urandom_range(0, 5) == 0);
            applyStimulus(d, stopBit, parBit, int'($urandom_range(0, 2)));
        end
        drainByte();
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("leftover expected bits", bitQ.size(), 0);
        checkOutput("leftover expected bytes", byteQ.size(), 0);
        checkOutput("leftover expected errors", errQ.size(), 0);
        checkOutput("final byte_valid", bus.byte_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
